// File: rtl/minterm_scanner_pkg.sv
// rtl/minterm_scanner_pkg.sv - shared types and defaults for the minterm scanner
package minterm_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int NVEC = 2 ** N_IN_DEFAULT;

  // Prefixed so the SETTLE state cannot collide with the SETTLE parameter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/minterm_scanner_emitter.sv
// rtl/minterm_scanner_emitter.sv - walks a completed mask and streams set minterm indices
module minterm_emitter
  import minterm_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2**N_IN-1:0]   mask,
  input  logic                 go,
  output logic [N_IN-1:0]      idx,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 last
);

  logic            active;
  logic [N_IN-1:0] ptr;
  logic            hit;
  logic            adv;
  logic            at_end;

  // A clear bit is skipped in one cycle; a set bit waits for the consumer.
  always_comb begin
    hit    = active & mask[ptr];
    adv    = active & (~mask[ptr] | idx_ready);
    at_end = (ptr == {N_IN{1'b1}});
  end

  assign idx       = ptr;
  assign idx_valid = hit;
  assign last      = adv & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      ptr    <= '0;
    end else if (go) begin
      active <= 1'b1;
      ptr    <= '0;
    end else if (adv) begin
      if (at_end) begin
        active <= 1'b0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sweeps all input vectors of a Boolean function and records its minterms
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      drive,
  input  logic                 y_in,
  output logic                 busy,
  output logic [2**N_IN-1:0]   mask,
  output logic                 mask_valid,
  output logic [N_IN:0]        count,
  output logic [N_IN-1:0]      idx,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 done
);

  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  // With no settle cycles each vector is sampled in the cycle it is driven.
  localparam state_t VEC_ENTRY = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t     state;
  logic [3:0] settle_cnt;
  logic       emit_go;
  logic       emit_last;

  assign emit_go = (state == ST_SAMPLE) && (drive == {N_IN{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      drive      <= '0;
      busy       <= 1'b0;
      mask       <= '0;
      mask_valid <= 1'b0;
      count      <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= VEC_ENTRY;
            settle_cnt <= SETTLE_LOAD;
            drive      <= '0;
            busy       <= 1'b1;
            mask       <= '0;
            mask_valid <= 1'b0;
            count      <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          mask[drive] <= y_in;
          count       <= count + (N_IN+1)'(y_in);
          if (drive == {N_IN{1'b1}}) begin
            state      <= ST_EMIT;
            mask_valid <= 1'b1;
          end else begin
            drive      <= drive + 1'b1;
            state      <= VEC_ENTRY;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_EMIT: begin
          if (emit_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  minterm_emitter #(
    .N_IN (N_IN)
  ) u_emitter (
    .clk       (clk),
    .rst       (rst),
    .mask      (mask),
    .go        (emit_go),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .last      (emit_last)
  );

endmodule

// File: tb/tb_minterm_scanner.sv
// tb/tb_minterm_scanner.sv - scoreboard bench for minterm_scanner against a truth-table model
module tb_minterm_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  drive;
  logic        y_in;
  logic        busy;
  logic [15:0] mask;
  logic        mask_valid;
  logic [4:0]  count;
  logic [3:0]  idx;
  logic        idx_valid;
  logic        idx_ready;
  logic        done;

  logic [15:0] tt;
  int          n_vec;
  int          n_miss;
  int          exp_idx[$];
  logic [15:0] exp_mask[$];

  bit          rand_ready;
  int          stall_idx;
  int          stall_left;
  int          stall_seen;
  int          done_seen;
  bit          hold_pend;
  logic [3:0]  hold_idx;
  bit          mv_prev;

  minterm_scanner #(.N_IN(4), .SETTLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drive      (drive),
    .y_in       (y_in),
    .busy       (busy),
    .mask       (mask),
    .mask_valid (mask_valid),
    .count      (count),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .done       (done)
  );

  // The function under test is just a truth table indexed by the driven vector.
  assign y_in = tt[drive];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (stall_left > 0 && idx_valid && int'(idx) == stall_idx) begin
      idx_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      idx_ready = 1'($urandom_range(0, 1));
    end else begin
      idx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      mv_prev   = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(idx_valid), 64'd1);
        chk("hold_idx", 64'(idx), 64'(hold_idx));
      end
      hold_pend = idx_valid && !idx_ready;
      hold_idx  = idx;
      if (idx_valid && !idx_ready && idx == 4'd2) stall_seen++;
      if (idx_valid && idx_ready) begin
        if (exp_idx.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL idx_unexpected: got %0d expected no transfer", idx);
        end else begin
          chk("idx", 64'(idx), 64'(exp_idx.pop_front()));
        end
      end
      if (mask_valid && !mv_prev) begin
        if (exp_mask.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL mask_unexpected: got %0h expected no result", mask);
        end else begin
          logic [15:0] m;
          m = exp_mask.pop_front();
          chk("mask", 64'(mask), 64'(m));
          chk("count", 64'(count), 64'($countones(m)));
        end
      end
      if (done) done_seen++;
      mv_prev = mask_valid;
    end
  end

  task automatic run_scan(input logic [15:0] f, input bit pulse_mid, input int exp_done_dly);
    int cyc;
    int stall0;
    int done0;
    tt = f;
    exp_mask.push_back(f);
    for (int k = 0; k < 16; k++) if (f[k]) exp_idx.push_back(k);
    stall0 = stall_seen;
    done0  = done_seen;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("drive_first", 64'(drive), 64'd0);
    cyc = 0;
    while (!mask_valid && cyc < 200) begin
      start = pulse_mid && (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("scan_latency", 64'(cyc), 64'd32);
    chk("drive_hold", 64'(drive), 64'hF);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    if (exp_done_dly >= 0) chk("done_delay", 64'(cyc), 64'(exp_done_dly));
    @(posedge clk); #1;
    chk("done_once", 64'(done), 64'd0);
    chk("done_count", 64'(done_seen - done0), 64'd1);
    chk("mask_hold", 64'(mask), 64'(f));
    chk("count_hold", 64'(count), 64'($countones(f)));
    chk("mask_valid_hold", 64'(mask_valid), 64'd1);
    chk("idx_all_sent", 64'(exp_idx.size()), 64'd0);
    if (stall_idx >= 0) chk("stall_cycles", 64'(stall_seen - stall0), 64'd5);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; start = 1'b0; tt = '0; idx_ready = 1'b0;
    rand_ready = 1'b0; stall_idx = -1; stall_left = 0;
    stall_seen = 0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 64'({drive, busy, mask, mask_valid}), 64'd0);
    chk("reset_b", 64'({count, idx, idx_valid, done}), 64'd0);
    rst = 1'b0;

    run_scan(16'h001E, 1'b0, 16);
    run_scan(16'h0000, 1'b0, 16);
    run_scan(16'hFFFF, 1'b0, 16);

    stall_idx = 2; stall_left = 5;
    run_scan(16'h001E, 1'b0, 21);
    stall_idx = -1; stall_left = 0;

    run_scan(16'h001E, 1'b1, 16);

    // Abort a scan at vector 7 with an asynchronous reset.
    tt = 16'h001E;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && drive != 4'd7; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_drive7", 64'(drive), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_a", 64'({drive, busy, mask, mask_valid}), 64'd0);
    chk("abort_b", 64'({count, idx, idx_valid, done}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_scan(16'h001E, 1'b0, 16);

    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      run_scan(16'($urandom), 1'b0, -1);
    end
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
